// File: rtl/quadrature_debounce_pkg.sv
// -----------------------------------------------------------------------------
// quadrature_debounce_pkg
//   Shared helper for the quadrature input conditioner: derives counter widths
//   from the user parameters so the top and the channel filter size their
//   counters the same way.
//   No ports.
// -----------------------------------------------------------------------------
package quadrature_debounce_pkg;

  // Width needed to hold 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : quadrature_debounce_pkg

// File: rtl/quadrature_debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   One encoder channel: SYNC_STAGES-deep synchronizer followed by a
//   tick-sampled stability filter. The output only follows the synchronized
//   input after STABLE_COUNT consecutive disagreeing ticks; any agreeing tick
//   restarts the count.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   tick     in   sample enable from the shared divider
//   raw_in   in   raw, asynchronous channel pin
//   out      out  debounced level, registered
//   changed  out  high on the tick whose clock edge updates out
// -----------------------------------------------------------------------------
module debounce_channel
  import quadrature_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned STABLE_COUNT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic raw_in,
  output logic out,
  output logic changed
);

  localparam int unsigned CW = cnt_width(STABLE_COUNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_COUNT - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_out;
  logic                   w_s;
  logic                   w_differ;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_differ = (w_s != r_out);
  // Combinational so the top can register step_err on the same edge that
  // updates the outputs, making it visible during the following cycle.
  assign changed  = tick & w_differ & (r_cnt == CNT_LAST);
  assign out      = r_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_out  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
      if (tick) begin
        if (!w_differ) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_out <= w_s;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

endmodule : debounce_channel

// File: rtl/quadrature_debounce.sv
// -----------------------------------------------------------------------------
// quadrature_debounce
//   Two-channel conditioner in front of the rotary-encoder decoder. Each raw
//   pin is synchronized and debounced; a shared divider sets the sample rate.
//   step_err flags an illegal quadrature step (both outputs moving on the same
//   tick). Both outputs still update; the flag only reports.
// Ports:
//   clk       in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   a_in      in   raw encoder channel A (asynchronous)
//   b_in      in   raw encoder channel B (asynchronous)
//   a_out     out  debounced A, registered
//   b_out     out  debounced B, registered
//   step_err  out  one-cycle pulse after a tick that changed both outputs
// -----------------------------------------------------------------------------
module quadrature_debounce
  import quadrature_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned TICK_DIV     = 1,
  parameter int unsigned STABLE_COUNT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic a_in,
  input  logic b_in,
  output logic a_out,
  output logic b_out,
  output logic step_err
);

  localparam int unsigned DW = cnt_width(TICK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

  logic [DW-1:0] r_div;
  logic          r_step_err;
  logic          w_tick;
  logic          w_changed_a;
  logic          w_changed_b;

  // With TICK_DIV=1 DIV_LAST is 0 and r_div never leaves 0, so tick is
  // permanently high.
  assign w_tick   = (r_div == DIV_LAST);
  assign step_err = r_step_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div      <= '0;
      r_step_err <= 1'b0;
    end else begin
      r_div      <= w_tick ? '0 : r_div + DW'(1);
      r_step_err <= w_changed_a & w_changed_b;
    end
  end

  debounce_channel #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_COUNT (STABLE_COUNT)
  ) u_chan_a (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (w_tick),
    .raw_in  (a_in),
    .out     (a_out),
    .changed (w_changed_a)
  );

  debounce_channel #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_COUNT (STABLE_COUNT)
  ) u_chan_b (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (w_tick),
    .raw_in  (b_in),
    .out     (b_out),
    .changed (w_changed_b)
  );

endmodule : quadrature_debounce
